// File: rtl/fft_peak_bin_detector.sv
`default_nettype none
// ============================================================================
// Module      : fft_peak_bin_detector
// Description : Per-bin power (re^2 + im^2) of a 64-point FFT output stream.
//               Reports the strongest bin of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_bin_detector #(
  parameter int NPOINT = 64,
  parameter int DW     = 16,
  parameter int IDXW   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*DW-1:0]   din,
  input  logic              din_val,
  input  logic              clr,
  output logic [2*DW-1:0]   pow_out,
  output logic [IDXW-1:0]   pow_idx,
  output logic              pow_val,
  output logic [IDXW-1:0]   peak_idx,
  output logic [2*DW-1:0]   peak_pow,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [IDXW-1:0] c_last_idx = IDXW'(NPOINT - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_bin_cnt;

  logic              r_s1_val;
  logic [IDXW-1:0]   r_s1_idx;
  logic [2*DW-2:0]   r_re_sq;
  logic [2*DW-2:0]   r_im_sq;

  logic              r_s2_val;
  logic [IDXW-1:0]   r_s2_idx;
  logic [2*DW-1:0]   r_pow;

  logic [IDXW-1:0]   r_max_idx;
  logic [2*DW-1:0]   r_max_pow;
  logic [IDXW-1:0]   r_peak_idx;
  logic [2*DW-1:0]   r_peak_pow;
  logic              r_frame_done;

  logic [2*DW-2:0]   w_re_ext;
  logic [2*DW-2:0]   w_im_ext;
  logic [2*DW-2:0]   w_re_sq;
  logic [2*DW-2:0]   w_im_sq;
  logic [2*DW-1:0]   w_sum;
  logic              w_new_max;
  logic              w_last;

  // Squares of sign-extended operands are exact modulo 2^(2*DW-1); the true
  // value never exceeds 2^(2*DW-2), so the low bits are the whole result.
  assign w_re_ext  = {{(DW-1){din[2*DW-1]}}, din[2*DW-1:DW]};
  assign w_im_ext  = {{(DW-1){din[DW-1]}},   din[DW-1:0]};
  assign w_re_sq   = w_re_ext * w_re_ext;
  assign w_im_sq   = w_im_ext * w_im_ext;
  assign w_sum     = {1'b0, r_re_sq} + {1'b0, r_im_sq};

  assign w_new_max = (r_s2_idx == '0) || (r_pow > r_max_pow);
  assign w_last    = r_s2_val && (r_s2_idx == c_last_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin_cnt    <= '0;
      r_s1_val     <= 1'b0;
      r_s1_idx     <= '0;
      r_re_sq      <= '0;
      r_im_sq      <= '0;
      r_s2_val     <= 1'b0;
      r_s2_idx     <= '0;
      r_pow        <= '0;
      r_max_idx    <= '0;
      r_max_pow    <= '0;
      r_peak_idx   <= '0;
      r_peak_pow   <= '0;
      r_frame_done <= 1'b0;
    end else if (clr) begin
      r_bin_cnt    <= '0;
      r_s1_val     <= 1'b0;
      r_s2_val     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_s1_val <= din_val;
      if (din_val) begin
        r_s1_idx  <= r_bin_cnt;
        r_re_sq   <= w_re_sq;
        r_im_sq   <= w_im_sq;
        r_bin_cnt <= r_bin_cnt + 1'b1;
      end

      r_s2_val <= r_s1_val;
      if (r_s1_val) begin
        r_s2_idx <= r_s1_idx;
        r_pow    <= w_sum;
      end

      // Strict compare keeps the lower index on ties.
      if (r_s2_val && w_new_max) begin
        r_max_idx <= r_s2_idx;
        r_max_pow <= r_pow;
      end

      r_frame_done <= w_last;
      if (w_last) begin
        r_peak_idx <= w_new_max ? r_s2_idx : r_max_idx;
        r_peak_pow <= w_new_max ? r_pow    : r_max_pow;
      end
    end
  end

  // After a wrap the counter reads 0; a missing din_val there ends the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (clr) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (din_val) r_state <= S_ACCUM;
        S_ACCUM: if ((r_bin_cnt == '0) && !din_val) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pow_out    = r_pow;
  assign pow_idx    = r_s2_idx;
  assign pow_val    = r_s2_val;
  assign peak_idx   = r_peak_idx;
  assign peak_pow   = r_peak_pow;
  assign frame_done = r_frame_done;
  assign busy       = (r_state == S_ACCUM) || r_s1_val || r_s2_val;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_bin_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_peak_bin_detector
// Description : Directed self-checking bench for fft_peak_bin_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_peak_bin_detector;

  localparam int NPOINT = 64;
  localparam int DW     = 16;
  localparam int IDXW   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2*DW-1:0]   din = '0;
  logic              din_val = 1'b0;
  logic              clr = 1'b0;
  logic [2*DW-1:0]   pow_out;
  logic [IDXW-1:0]   pow_idx;
  logic              pow_val;
  logic [IDXW-1:0]   peak_idx;
  logic [2*DW-1:0]   peak_pow;
  logic              frame_done;
  logic              busy;

  int     n_checks = 0;
  int     n_errors = 0;
  int     tb_bin   = 0;
  longint cyc      = 0;
  int     fd_count = 0;
  longint fd_cyc[$];
  longint fd_idx[$];
  longint fd_pow[$];

  logic              ev1 = 1'b0, ev2 = 1'b0;
  logic [2*DW-1:0]   ep1 = '0,   ep2 = '0;
  logic [IDXW-1:0]   ei1 = '0,   ei2 = '0;

  fft_peak_bin_detector #(.NPOINT(NPOINT), .DW(DW), .IDXW(IDXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_val    (din_val),
    .clr        (clr),
    .pow_out    (pow_out),
    .pow_idx    (pow_idx),
    .pow_val    (pow_val),
    .peak_idx   (peak_idx),
    .peak_pow   (peak_pow),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bpow(input logic [31:0] d);
    longint re, im, p;
    re = longint'($signed(d[31:16]));
    im = longint'($signed(d[15:0]));
    p  = re * re + im * im;
    return p[31:0];
  endfunction

  // Two-cycle expectation delay line for the per-bin power stream.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev1 <= 1'b0;
      ev2 <= 1'b0;
    end else begin
      ev2 <= clr ? 1'b0 : ev1;
      ep2 <= ep1;
      ei2 <= ei1;
      ev1 <= din_val & ~clr;
      ep1 <= bpow(din);
      ei1 <= IDXW'(tb_bin);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    check("pow_val", longint'(pow_val), longint'(ev2));
    if (ev2) begin
      check("pow_out", longint'(pow_out), longint'(ep2));
      check("pow_idx", longint'(pow_idx), longint'(ei2));
    end
    if (frame_done) begin
      fd_count++;
      fd_cyc.push_back(cyc);
      fd_idx.push_back(longint'(peak_idx));
      fd_pow.push_back(longint'(peak_pow));
    end
  end

  task automatic send(input int bin, input int re, input int im, input int gap);
    din     = {16'(re), 16'(im)};
    din_val = 1'b1;
    tb_bin  = bin;
    @(posedge clk); #1;
    din_val = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input int pk, input int re, input int im, input bit noise, input bit rgap);
    for (int b = 0; b < NPOINT; b++) begin
      int g;
      g = (rgap && b != NPOINT - 1) ? int'($urandom_range(0, 3)) : 0;
      if (b == pk) send(b, re, im, g);
      else         send(b, noise ? (b & 7) : 0, noise ? 1 : 0, g);
    end
  endtask

  task automatic expect_frame(input string tag, input longint idx, input longint pw);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 20);
    check({tag, "_lat"}, longint'(n), 3);
    check({tag, "_idx"}, longint'(peak_idx), idx);
    check({tag, "_pow"}, longint'(peak_pow), pw);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pow_out"},    longint'(pow_out), 0);
    check({tag, "_pow_idx"},    longint'(pow_idx), 0);
    check({tag, "_pow_val"},    longint'(pow_val), 0);
    check({tag, "_peak_idx"},   longint'(peak_idx), 0);
    check({tag, "_peak_pow"},   longint'(peak_pow), 0);
    check({tag, "_frame_done"}, longint'(frame_done), 0);
    check({tag, "_busy"},       longint'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Single bin above a zero floor.
    fd0 = fd_count;
    frame(5, 100, 0, 1'b0, 1'b0);
    expect_frame("t1", 5, 10000);
    repeat (5) @(negedge clk);
    check("t1_fd_once", longint'(fd_count - fd0), 1);
    check("t1_busy_idle", longint'(busy), 0);

    // Full-scale tie: the lower index must win.
    @(posedge clk); #1;
    for (int b = 0; b < NPOINT; b++) begin
      if (b == 9 || b == 40) send(b, -32768, -32768, 0);
      else                   send(b, 0, 0, 0);
    end
    expect_frame("t2", 9, 32'h8000_0000);

    // Random gaps, peak in the last bin.
    @(posedge clk); #1;
    frame(63, 3, 4, 1'b0, 1'b1);
    expect_frame("t3", 63, 25);

    // Two back-to-back frames without a bubble.
    @(posedge clk); #1;
    fd0 = fd_count;
    frame(12, 1000, 0, 1'b1, 1'b0);
    frame(50, 0, -2000, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("t4_count", longint'(fd_count - fd0), 2);
    if (fd_count - fd0 >= 2) begin
      check("t4_spacing", fd_cyc[fd0 + 1] - fd_cyc[fd0], 64);
      check("t4_idx0", fd_idx[fd0], 12);
      check("t4_pow0", fd_pow[fd0], 1000000);
      check("t4_idx1", fd_idx[fd0 + 1], 50);
      check("t4_pow1", fd_pow[fd0 + 1], 4000000);
    end

    // Abort mid-frame: held peak survives, no frame_done.
    @(posedge clk); #1;
    frame(20, 500, 500, 1'b0, 1'b0);
    expect_frame("t5a", 20, 500000);
    @(posedge clk); #1;
    fd0 = fd_count;
    for (int b = 0; b < 30; b++) send(b, (b == 3) ? 30000 : 0, 0, 0);
    check("t5_busy_mid", longint'(busy), 1);
    din     = {16'(32000), 16'(0)};
    din_val = 1'b1;
    clr     = 1'b1;
    tb_bin  = 30;
    @(posedge clk); #1;
    din_val = 1'b0;
    clr     = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_no_fd", longint'(fd_count - fd0), 0);
    check("t5_hold_idx", longint'(peak_idx), 20);
    check("t5_hold_pow", longint'(peak_pow), 500000);
    check("t5_busy_after", longint'(busy), 0);
    @(posedge clk); #1;
    frame(7, -7, -7, 1'b0, 1'b0);
    expect_frame("t5c", 7, 98);

    // Asynchronous reset in the middle of a frame.
    @(posedge clk); #1;
    for (int b = 0; b < 20; b++) send(b, (b == 4) ? 1000 : 0, 1000, 0);
    rst = 1'b0;
    #2;
    check_all_zero("t6_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    frame(33, 123, -45, 1'b0, 1'b0);
    expect_frame("t6", 33, 17154);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
